dmem_responder: RTL

- Responder side of the pipeline data-memory interface. Accepts one load or store request at a time on the dmem_* port and returns dmem_rdata/dmem_resp.
- Serves each request from a word-wide backing memory over a bmem_* read/write handshake.
- The backing memory has no byte strobes, so partial stores are performed as read-modify-write.
- A watchdog bounds how long the block waits for the backing memory.

---
 rtl/dmem_responder_pkg.sv | 45 ++++
 rtl/dmem_responder_if.sv | 62 ++++++
 rtl/dmem_responder.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_types
// Shared types and helpers for the data-memory responder.
//   - dmem_resp_state_t : responder FSM states
//   - DMEM_TIMEOUT      : default backing-memory watchdog limit in cycles
//   - byte_merge()      : per-lane select between an old and a new word
//   - lane_keep()       : zero every lane whose mask bit is clear
// -----------------------------------------------------------------------------
package rv32i_types;

    // Default watchdog limit; a value of zero disables the watchdog.
    localparam logic [15:0] DMEM_TIMEOUT = 16'd255;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RMW_RD = 3'd2,
        WR     = 3'd3,
        DONE   = 3'd4
    } dmem_resp_state_t;

    // Lane i of the result comes from new_word when mask[i] is set,
    // otherwise from old_word.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  mask
    );
        logic [31:0] merged;
        merged[7:0]   = mask[0] ? new_word[7:0]   : old_word[7:0];
        merged[15:8]  = mask[1] ? new_word[15:8]  : old_word[15:8];
        merged[23:16] = mask[2] ? new_word[23:16] : old_word[23:16];
        merged[31:24] = mask[3] ? new_word[31:24] : old_word[31:24];
        return merged;
    endfunction

    // Keep only the lanes selected by mask; all other lanes read as zero.
    function automatic logic [31:0] lane_keep(
        input logic [31:0] word,
        input logic [3:0]  mask
    );
        return byte_merge(32'h0000_0000, word, mask);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Bundles the pipeline-side dmem_* request/response signals and the
// backing-memory bmem_* handshake of the data-memory responder.
//   slave  : the responder (consumes dmem requests, drives bmem requests)
//   master : the environment (pipeline requester plus backing memory)
// Signals:
//   dmem_addr/dmem_rmask/dmem_wmask/dmem_wdata  request from the pipeline
//   dmem_rdata/dmem_resp/dmem_err               completion to the pipeline
//   bmem_addr/bmem_read/bmem_write/bmem_wdata   request to the backing memory
//   bmem_rdata/bmem_resp                        completion from backing memory
// -----------------------------------------------------------------------------
interface dmem_responder_if;

    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        dmem_err;

    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_write;
    logic [31:0] bmem_wdata;
    logic [31:0] bmem_rdata;
    logic        bmem_resp;

    modport slave (
        input  dmem_addr,
        input  dmem_rmask,
        input  dmem_wmask,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_resp,
        output dmem_err,
        output bmem_addr,
        output bmem_read,
        output bmem_write,
        output bmem_wdata,
        input  bmem_rdata,
        input  bmem_resp
    );

    modport master (
        output dmem_addr,
        output dmem_rmask,
        output dmem_wmask,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_resp,
        input  dmem_err,
        input  bmem_addr,
        input  bmem_read,
        input  bmem_write,
        input  bmem_wdata,
        output bmem_rdata,
        output bmem_resp
    );

endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Responder side of the pipeline data-memory interface. Accepts one load or
// store at a time and serves it from a word-wide backing memory. Partial
// stores become read-modify-write because the backing memory has no byte
// strobes. A watchdog bounds every backing-memory phase.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : dmem_responder_if.slave (dmem_* request/response, bmem_* handshake)
// Parameters:
//   TIMEOUT : cycles to wait for bmem_resp in one phase; 0 disables the watchdog
// All outputs come from flops or are decoded from the state register, so no
// input reaches an output combinationally.
// -----------------------------------------------------------------------------
module dmem_responder
    import rv32i_types::*;
#(
    parameter logic [15:0] TIMEOUT = DMEM_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus
);

    dmem_resp_state_t state_q, state_d;

    logic [3:0]  rmask_q,   rmask_d;
    logic [3:0]  wmask_q,   wmask_d;
    logic [31:0] wdata_q,   wdata_d;
    logic        illegal_q, illegal_d;
    logic [15:0] wdog_q,    wdog_d;
    logic [31:0] rdata_q,   rdata_d;
    logic        err_q,     err_d;
    logic [31:0] baddr_q,   baddr_d;
    logic [31:0] bwdata_q,  bwdata_d;

    logic        req_s;
    logic        store_s;
    logic        wdog_expire_s;
    logic        unused_addr_lsb_s;

    assign req_s   = |(bus.dmem_rmask | bus.dmem_wmask);
    assign store_s = |bus.dmem_wmask;

    // Byte offset bits never reach the backing memory; lanes come from masks.
    assign unused_addr_lsb_s = ^bus.dmem_addr[1:0];

    // Expires in the cycle whose missing bmem_resp would bring the count to
    // TIMEOUT. A bmem_resp in that same cycle is checked first and wins.
    assign wdog_expire_s = (TIMEOUT != 16'd0) && ((wdog_q + 16'd1) == TIMEOUT);

    // Next-state, latch, merge and watchdog logic.
    always_comb begin
        state_d   = state_q;
        rmask_d   = rmask_q;
        wmask_d   = wmask_q;
        wdata_d   = wdata_q;
        illegal_d = illegal_q;
        wdog_d    = wdog_q;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
        baddr_d   = baddr_q;
        bwdata_d  = bwdata_q;

        case (state_q)
            IDLE: begin
                if (req_s) begin
                    rmask_d   = bus.dmem_rmask;
                    wmask_d   = bus.dmem_wmask;
                    wdata_d   = bus.dmem_wdata;
                    baddr_d   = {bus.dmem_addr[31:2], 2'b00};
                    illegal_d = store_s && (|bus.dmem_rmask);
                    rdata_d   = 32'h0000_0000;
                    wdog_d    = 16'd0;
                    if (store_s) begin
                        if (bus.dmem_wmask == 4'b1111) begin
                            // Full word: no need to read the old contents.
                            bwdata_d = bus.dmem_wdata;
                            state_d  = WR;
                        end else begin
                            state_d  = RMW_RD;
                        end
                    end else begin
                        state_d = RD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            RD: begin
                if (bus.bmem_resp) begin
                    rdata_d = lane_keep(bus.bmem_rdata, rmask_q);
                    state_d = DONE;
                end else if (wdog_expire_s) begin
                    rdata_d = 32'h0000_0000;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wdog_d  = wdog_q + 16'd1;
                end
            end

            RMW_RD: begin
                if (bus.bmem_resp) begin
                    bwdata_d = byte_merge(bus.bmem_rdata, wdata_q, wmask_q);
                    wdog_d   = 16'd0;
                    state_d  = WR;
                end else if (wdog_expire_s) begin
                    // Abandon the store entirely; the write is never issued.
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wdog_d  = wdog_q + 16'd1;
                end
            end

            WR: begin
                if (bus.bmem_resp) begin
                    err_d   = illegal_q;
                    state_d = DONE;
                end else if (wdog_expire_s) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wdog_d  = wdog_q + 16'd1;
                end
            end

            DONE: begin
                // Requests seen here are ignored, forcing one bubble.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rmask_q   <= 4'b0000;
            wmask_q   <= 4'b0000;
            wdata_q   <= 32'h0000_0000;
            illegal_q <= 1'b0;
            wdog_q    <= 16'd0;
            rdata_q   <= 32'h0000_0000;
            err_q     <= 1'b0;
            baddr_q   <= 32'h0000_0000;
            bwdata_q  <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            rmask_q   <= rmask_d;
            wmask_q   <= wmask_d;
            wdata_q   <= wdata_d;
            illegal_q <= illegal_d;
            wdog_q    <= wdog_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            baddr_q   <= baddr_d;
            bwdata_q  <= bwdata_d;
        end
    end

    // Handshake strobes are pure state decodes, so read and write are
    // mutually exclusive by construction.
    assign bus.dmem_resp  = (state_q == DONE);
    assign bus.bmem_read  = (state_q == RD) || (state_q == RMW_RD);
    assign bus.bmem_write = (state_q == WR);

    assign bus.dmem_rdata = rdata_q;
    assign bus.dmem_err   = err_q;
    assign bus.bmem_addr  = baddr_q;
    assign bus.bmem_wdata = bwdata_q;

endmodule
